max6682_spi_fsm: RTL and testbench

SPI transaction sequencer for the MAX6682 temperature-sensor application in the reconfigurable logic. On a start request it drives the on-chip SPI master to clock two bytes out of the MAX6682 under chip select. It then pops both received bytes and presents them, with a done flag, to the MAX6682 application FSM, which converts them to `SensorValue_o` and decides on `CpuIntr_o`. It sits directly upstream of that FSM and supplies its `SPI_FSM_Done` input.

---
 rtl/max6682_pkg.sv | 27 ++
 rtl/spi_timeout_counter.sv | 39 +++
 rtl/max6682_spi_fsm.sv | 152 +++++++++++++++
 tb/tb_max6682_spi_fsm.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max6682_pkg.sv
// Shared definitions for the MAX6682 SPI transaction sequencer.
//   - state_t and the state constants (Idle=0 .. Rd2=6)
//   - MAX6682_DUMMY: byte pushed to the SPI master to generate SCK
//   - default watchdog width and timeout
//   - cs_active(): states in which the sensor chip select is held low
package max6682_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StTx1      = 3'd1;
  localparam state_t StTx2      = 3'd2;
  localparam state_t StWaitBusy = 3'd3;
  localparam state_t StWaitEnd  = 3'd4;
  localparam state_t StRd1      = 3'd5;
  localparam state_t StRd2      = 3'd6;

  localparam logic [7:0]  MAX6682_DUMMY           = 8'h00;
  localparam int unsigned MAX6682_TIMEOUT_WIDTH   = 16;
  localparam logic [15:0] MAX6682_TIMEOUT_DEFAULT = 16'd2000;

  // Chip select is low from Tx1 through WaitEnd; the encoding keeps these contiguous.
  function automatic logic cs_active(input state_t s);
    return (s >= StTx1) && (s <= StWaitEnd);
  endfunction

endpackage

// File: rtl/spi_timeout_counter.sv
// Watchdog counter for the MAX6682 SPI sequencer.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count this cycle
//   expire   : high while enabled in the Terminal-th cycle since the last clear
module spi_timeout_counter #(
  parameter int unsigned       Width    = 16,
  parameter logic [Width-1:0]  Terminal = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the cycles already spent, so Terminal-1 marks the last permitted one.
  assign expire = enable && (count_q == (Terminal - Width'(1)));

endmodule

// File: rtl/max6682_spi_fsm.sv
// SPI transaction sequencer for the MAX6682 temperature sensor.
// On Start_i it pushes two dummy bytes into the SPI master under chip select, waits for the
// shift to finish, pops both received bytes and presents them with a Done_o level.
//   Clk_i, Reset_i          : clock, asynchronous active-high reset
//   Start_i                 : transaction request, sampled only in Idle
//   Done_o, Error_o         : result valid level / one-cycle timeout-abort pulse
//   Byte1_o, Byte0_o        : first (D15..D8) and second (D7..D0) received bytes
//   MAX6682CS_n_o           : sensor chip select, active low
//   SPI_Write_o, SPI_Data_o : TX FIFO push strobe and data (constant DummyByte)
//   SPI_ReadNext_o          : RX FIFO pop strobe
//   SPI_Data_i, SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i : SPI master status
module max6682_spi_fsm
  import max6682_pkg::*;
#(
  parameter int unsigned             TimeoutWidth  = MAX6682_TIMEOUT_WIDTH,
  parameter logic [TimeoutWidth-1:0] TimeoutCycles = TimeoutWidth'(MAX6682_TIMEOUT_DEFAULT),
  parameter logic [7:0]              DummyByte     = MAX6682_DUMMY
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Start_i,
  output logic       Done_o,
  output logic       Error_o,
  output logic [7:0] Byte1_o,
  output logic [7:0] Byte0_o,
  output logic       MAX6682CS_n_o,
  output logic       SPI_Write_o,
  output logic       SPI_ReadNext_o,
  output logic [7:0] SPI_Data_o,
  input  logic [7:0] SPI_Data_i,
  input  logic       SPI_FIFOFull_i,
  input  logic       SPI_FIFOEmpty_i,
  input  logic       SPI_Transmission_i
);

  state_t     state_q, state_d;
  logic [7:0] byte1_q, byte1_d;
  logic [7:0] byte0_q, byte0_d;
  logic       done_q, done_d;
  logic       error_q;
  logic       cs_n_q;
  logic       spi_write, spi_read;
  logic       advance, abort, expire;
  logic       cnt_clear, cnt_enable;

  always_comb begin
    state_d   = state_q;
    byte1_d   = byte1_q;
    byte0_d   = byte0_q;
    done_d    = done_q;
    spi_write = 1'b0;
    spi_read  = 1'b0;
    advance   = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start_i) begin
          state_d = StTx1;
          done_d  = 1'b0;
        end
      end
      StTx1, StTx2: begin
        if (!SPI_FIFOFull_i) begin
          spi_write = 1'b1;
          advance   = 1'b1;
          state_d   = (state_q == StTx1) ? StTx2 : StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (SPI_Transmission_i) begin
          advance = 1'b1;
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (!SPI_Transmission_i) begin
          advance = 1'b1;
          state_d = StRd1;
        end
      end
      StRd1: begin
        if (!SPI_FIFOEmpty_i) begin
          spi_read = 1'b1;
          advance  = 1'b1;
          byte1_d  = SPI_Data_i;
          state_d  = StRd2;
        end
      end
      StRd2: begin
        if (!SPI_FIFOEmpty_i) begin
          spi_read = 1'b1;
          advance  = 1'b1;
          byte0_d  = SPI_Data_i;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A satisfied wait condition beats a simultaneous watchdog expiry.
    if (expire && !advance) begin
      abort   = 1'b1;
      state_d = StIdle;
    end
  end

  assign cnt_clear  = (state_d != state_q);
  assign cnt_enable = (state_q != StIdle);

  spi_timeout_counter #(
    .Width    (TimeoutWidth),
    .Terminal (TimeoutCycles)
  ) u_timeout (
    .clk    (Clk_i),
    .rst    (Reset_i),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expire (expire)
  );

  // CS is registered from the next state so it is glitch-free yet still low in the first Tx1
  // cycle; the asynchronous reset forces it high immediately.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= StIdle;
      byte1_q <= 8'h00;
      byte0_q <= 8'h00;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      byte1_q <= byte1_d;
      byte0_q <= byte0_d;
      done_q  <= done_d;
      error_q <= abort;
      cs_n_q  <= !cs_active(state_d);
    end
  end

  assign Done_o         = done_q;
  assign Error_o        = error_q;
  assign Byte1_o        = byte1_q;
  assign Byte0_o        = byte0_q;
  assign MAX6682CS_n_o  = cs_n_q;
  assign SPI_Write_o    = spi_write;
  assign SPI_ReadNext_o = spi_read;
  assign SPI_Data_o     = DummyByte;

endmodule

// File: tb/tb_max6682_spi_fsm.sv
// Self-checking bench for max6682_spi_fsm: an SPI master environment model drives the DUT,
// a transaction-level reference model predicts every output on every cycle, and directed
// scenarios pin the model with hand-computed literals.
module tb_max6682_spi_fsm;

  localparam int TO = 40;

  logic       Clk_i = 1'b0;
  logic       Reset_i, Start_i;
  logic       Done_o, Error_o;
  logic [7:0] Byte1_o, Byte0_o;
  logic       MAX6682CS_n_o, SPI_Write_o, SPI_ReadNext_o;
  logic [7:0] SPI_Data_o, SPI_Data_i;
  logic       SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i;

  always #5 Clk_i = ~Clk_i;

  max6682_spi_fsm #(
    .TimeoutWidth  (16),
    .TimeoutCycles (16'(TO)),
    .DummyByte     (8'h00)
  ) dut (
    .Clk_i              (Clk_i),
    .Reset_i            (Reset_i),
    .Start_i            (Start_i),
    .Done_o             (Done_o),
    .Error_o            (Error_o),
    .Byte1_o            (Byte1_o),
    .Byte0_o            (Byte0_o),
    .MAX6682CS_n_o      (MAX6682CS_n_o),
    .SPI_Write_o        (SPI_Write_o),
    .SPI_ReadNext_o     (SPI_ReadNext_o),
    .SPI_Data_o         (SPI_Data_o),
    .SPI_Data_i         (SPI_Data_i),
    .SPI_FIFOFull_i     (SPI_FIFOFull_i),
    .SPI_FIFOEmpty_i    (SPI_FIFOEmpty_i),
    .SPI_Transmission_i (SPI_Transmission_i)
  );

  int checks = 0;
  int errors = 0;

  // SPI master environment
  int         e_tx, e_busy_left, e_busy_len, e_full_left;
  bit         e_trans, e_stuck, e_rand;
  logic [7:0] e_rx[$];
  logic [7:0] e_src[$];

  // Reference model: progress of the current transaction, not a state register
  bit         m_active, m_busy_seen, m_ended, m_done, m_err;
  int         m_writes, m_reads, m_wait;
  logic [7:0] m_b1, m_b0;

  // Observations
  int n_writes, n_reads, n_done_cycles, n_err, cyc, last_write_cyc, err_cyc;
  bit ev_done, ev_err, prev_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_busy_seen = 0; m_ended = 0; m_done = 0; m_err = 0;
    m_writes = 0; m_reads = 0; m_wait = 0; m_b1 = 8'h00; m_b0 = 8'h00;
  endtask

  task automatic env_reset();
    e_tx = 0; e_busy_left = 0; e_full_left = 0; e_trans = 0;
    e_rx.delete();
  endtask

  task automatic apply_env();
    SPI_Transmission_i = e_trans;
    SPI_FIFOFull_i     = (e_full_left > 0);
    SPI_FIFOEmpty_i    = (e_rx.size() == 0);
    SPI_Data_i         = (e_rx.size() > 0) ? e_rx[0] : 8'h00;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit prog, err_n;
    prog = 1'b0;
    err_n = 1'b0;
    if (!m_active) begin
      if (Start_i) begin
        m_active = 1; m_writes = 0; m_reads = 0; m_busy_seen = 0; m_ended = 0;
        m_wait = 0; m_done = 0;
      end
    end else begin
      if (m_writes < 2) begin
        if (!SPI_FIFOFull_i) begin m_writes++; prog = 1; end
      end else if (!m_busy_seen) begin
        if (SPI_Transmission_i) begin m_busy_seen = 1; prog = 1; end
      end else if (!m_ended) begin
        if (!SPI_Transmission_i) begin m_ended = 1; prog = 1; end
      end else if (!SPI_FIFOEmpty_i) begin
        if (m_reads == 0) m_b1 = SPI_Data_i;
        else m_b0 = SPI_Data_i;
        m_reads++;
        prog = 1;
        if (m_reads == 2) begin m_done = 1; m_active = 0; end
      end
      if (prog) m_wait = 0;
      else if (m_wait == TO - 1) begin m_active = 0; err_n = 1; end
      else m_wait++;
    end
    m_err = err_n;
  endtask

  task automatic env_step(input bit w, input bit r);
    if (r && e_rx.size() > 0) e_rx.delete(0);
    if (w) e_tx++;
    if (e_full_left > 0) e_full_left--;
    if (e_rand && e_full_left == 0 && $urandom_range(0, 5) == 0)
      e_full_left = int'($urandom_range(1, 4));
    if (e_trans) begin
      e_busy_left--;
      if (e_busy_left <= 0) begin
        e_trans = 0;
        for (int k = 0; k < 2; k++)
          e_rx.push_back(e_src.size() > 0 ? e_src.pop_front() : 8'($urandom));
      end
    end else if (e_tx >= 2 && !e_stuck) begin
      e_tx -= 2;
      e_trans = 1;
      e_busy_left = e_rand ? int'($urandom_range(1, 48)) : e_busy_len;
    end
  endtask

  task automatic compare();
    chk("cs_n", MAX6682CS_n_o, !(m_active && !m_ended));
    chk("spi_write", SPI_Write_o, m_active && m_writes < 2 && !SPI_FIFOFull_i);
    chk("spi_readnext", SPI_ReadNext_o,
        m_active && m_ended && m_reads < 2 && !SPI_FIFOEmpty_i);
    chk("spi_data", SPI_Data_o, 8'h00);
    chk("done", Done_o, m_done);
    chk("error", Error_o, m_err);
    chk("byte1", Byte1_o, m_b1);
    chk("byte0", Byte0_o, m_b0);
  endtask

  task automatic tick();
    bit w, r;
    @(negedge Clk_i);
    compare();
    w = SPI_Write_o;
    r = SPI_ReadNext_o;
    if (w) begin n_writes++; last_write_cyc = cyc; end
    if (r) n_reads++;
    if (Done_o) n_done_cycles++;
    if (Error_o) begin n_err++; ev_err = 1; err_cyc = cyc; end
    if (Done_o && !prev_done) ev_done = 1;
    prev_done = Done_o;
    cyc++;
    if (!Reset_i) model_step();
    env_step(w, r);
    @(posedge Clk_i);
    #1;
    apply_env();
  endtask

  task automatic run_until(input string name, input int maxc, input bit want_err);
    bit hit;
    ev_done = 0;
    ev_err = 0;
    hit = 0;
    for (int k = 0; k < maxc && !hit; k++) begin
      tick();
      hit = want_err ? ev_err : ev_done;
    end
    chk(name, hit, 1'b1);
  endtask

  task automatic start_pulse();
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w0, d0, e0, r0;
    Reset_i = 1'b1; Start_i = 1'b0;
    e_stuck = 0; e_rand = 0; e_busy_len = 32;
    n_writes = 0; n_reads = 0; n_done_cycles = 0; n_err = 0; cyc = 0;
    last_write_cyc = 0; err_cyc = 0; prev_done = 0;
    model_reset();
    env_reset();
    apply_env();
    #1;
    chk("reset_cs_n", MAX6682CS_n_o, 1'b1);
    chk("reset_done", Done_o, 1'b0);
    chk("reset_error", Error_o, 1'b0);
    chk("reset_bytes", {Byte1_o, Byte0_o}, 16'h0000);
    chk("reset_strobes", {SPI_Write_o, SPI_ReadNext_o}, 2'b00);
    tick();
    tick();
    Reset_i = 1'b0;

    // Nominal: 32-cycle shift, RX returns 19 then A0
    e_src = '{8'h19, 8'hA0};
    w0 = n_writes; e0 = n_err; r0 = n_reads;
    start_pulse();
    run_until("nominal_wait", 200, 0);
    chk("nominal_byte1", Byte1_o, 8'h19);
    chk("nominal_byte0", Byte0_o, 8'hA0);
    chk("nominal_done", Done_o, 1'b1);
    chk("nominal_writes", n_writes - w0, 2);
    chk("nominal_reads", n_reads - r0, 2);
    chk("nominal_no_error", n_err - e0, 0);

    // Backpressure: TX FIFO full for the first 5 Tx1 cycles
    e_src = '{8'h5A, 8'h3C};
    w0 = n_writes;
    start_pulse();
    e_full_left = 5;
    apply_env();
    repeat (5) tick();
    chk("bp_no_write_while_full", n_writes - w0, 0);
    tick();
    chk("bp_write_on_release", n_writes - w0, 1);
    run_until("bp_wait", 200, 0);
    chk("bp_writes", n_writes - w0, 2);
    chk("bp_bytes", {Byte1_o, Byte0_o}, 16'h5A3C);

    // Timeout: transmission never starts; abort after TO cycles in WaitBusy
    e_stuck = 1;
    start_pulse();
    run_until("timeout_wait", 200, 1);
    chk("timeout_latency", err_cyc - last_write_cyc, TO + 1);
    chk("timeout_cs_n", MAX6682CS_n_o, 1'b1);
    chk("timeout_done", Done_o, 1'b0);
    chk("timeout_bytes_kept", {Byte1_o, Byte0_o}, 16'h5A3C);
    tick();
    chk("timeout_error_one_cycle", Error_o, 1'b0);
    e_stuck = 0;
    e_tx = 0;

    // Reset during WaitEnd
    e_src = '{8'h11, 8'h22};
    start_pulse();
    for (int k = 0; k < 20 && !SPI_Transmission_i; k++) tick();
    repeat (5) tick();
    chk("rst_mid_cs_low_before", MAX6682CS_n_o, 1'b0);
    Reset_i = 1'b1;
    #1;
    chk("rst_mid_cs_n", MAX6682CS_n_o, 1'b1);
    chk("rst_mid_done", Done_o, 1'b0);
    chk("rst_mid_error", Error_o, 1'b0);
    chk("rst_mid_bytes", {Byte1_o, Byte0_o}, 16'h0000);
    model_reset();
    env_reset();
    e_src.delete();
    apply_env();
    tick();
    tick();
    Reset_i = 1'b0;
    e_src = '{8'h33, 8'h44};
    start_pulse();
    run_until("rst_retry_wait", 200, 0);
    chk("rst_retry_bytes", {Byte1_o, Byte0_o}, 16'h3344);

    // Back-to-back with Start_i held
    e_busy_len = 8;
    e_src = '{8'h01, 8'h02, 8'h03, 8'h04};
    Start_i = 1'b1;
    tick();
    d0 = n_done_cycles;
    run_until("b2b_first_wait", 200, 0);
    Start_i = 1'b0;
    chk("b2b_first_bytes", {Byte1_o, Byte0_o}, 16'h0102);
    chk("b2b_restarted_cs", MAX6682CS_n_o, 1'b0);
    run_until("b2b_second_wait", 200, 0);
    chk("b2b_second_bytes", {Byte1_o, Byte0_o}, 16'h0304);
    chk("b2b_done_cycles", n_done_cycles - d0, 2);

    // Start pulse during WaitBusy is ignored
    e_busy_len = 16;
    e_src = '{8'h77, 8'h88};
    w0 = n_writes;
    start_pulse();
    for (int k = 0; k < 20 && (n_writes - w0) < 2; k++) tick();
    start_pulse();
    run_until("ign_wait", 200, 0);
    repeat (6) tick();
    chk("ign_writes", n_writes - w0, 2);
    chk("ign_bytes", {Byte1_o, Byte0_o}, 16'h7788);
    chk("ign_done_held", Done_o, 1'b1);

    // Randomized traffic: random starts, backpressure, shift lengths (some beyond TO) and data
    e_rand = 1;
    for (int k = 0; k < 3000; k++) begin
      Start_i = ($urandom_range(0, 9) == 0);
      tick();
    end
    Start_i = 1'b0;
    e_rand = 0;
    repeat (150) tick();
    chk("random_idle_at_end", MAX6682CS_n_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
